if_id_fetch: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID/EX register and feeds decode.
- Owns the PC, addresses instruction memory (MI), and latches PC+step and the fetched instruction for ID.
- Handles EX-resolved branch redirect (flush), external freeze, and load-use hazard detection against the instruction currently in ID/EX.
- On flush or hazard, requests a bubble in ID/EX.

---
 rtl/if_id_fetch.sv | 109 ++++++++++
 tb/tb_if_id_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, branch redirect, freeze and load-use stall.
// Define IF_ID_PERF_EN to build saturating stall/flush performance counters.
module if_id_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr_mem,
    output logic [31:0] pc_out,
    input  logic        desvio_ex,
    input  logic [31:0] alvo_desvio,
    input  logic        stall_ext,
    input  logic        idex_le_mem,
    input  logic [4:0]  idex_rd,
    output logic [31:0] saida_PC,
    output logic [31:0] saida_MI,
    output logic        saida_valido,
    output logic        bolha_idex,
    output logic [31:0] cont_stall,
    output logic [31:0] cont_flush
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        vld_id_q, vld_id_d;
    logic [31:0] pc_inc;
    logic        haz;
    logic        take_flush;
    logic        take_stall;

    assign pc_inc = pc_q + PC_STEP;

    // Both rs and rt fields are compared regardless of opcode; conservative but safe.
    assign haz = vld_id_q && idex_le_mem && (idex_rd != 5'd0) &&
                 ((idex_rd == instr_id_q[25:21]) || (idex_rd == instr_id_q[20:16]));

    assign take_flush = desvio_ex;
    assign take_stall = !desvio_ex && !stall_ext && haz;

    always_comb begin
        pc_d       = pc_inc;
        pc_id_d    = pc_inc;
        instr_id_d = instr_mem;
        vld_id_d   = 1'b1;
        if (desvio_ex) begin
            pc_d       = alvo_desvio;
            pc_id_d    = 32'd0;
            instr_id_d = NOP_INSTR;
            vld_id_d   = 1'b0;
        end else if (stall_ext || haz) begin
            pc_d       = pc_q;
            pc_id_d    = pc_id_q;
            instr_id_d = instr_id_q;
            vld_id_d   = vld_id_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            pc_id_q    <= 32'd0;
            instr_id_q <= NOP_INSTR;
            vld_id_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            vld_id_q   <= vld_id_d;
        end
    end

    assign pc_out       = pc_q;
    assign saida_PC     = pc_id_q;
    assign saida_MI     = instr_id_q;
    assign saida_valido = vld_id_q;
    assign bolha_idex   = reset_n && (take_flush || take_stall);

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (take_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (take_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cont_stall = stall_cnt_q;
    assign cont_flush = flush_cnt_q;
`else
    assign cont_stall = 32'd0;
    assign cont_flush = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed testbench for if_id_fetch: sequencing, load-use stall, redirect, freeze, wrap and reset.
module tb_if_id_fetch;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr_mem;
    logic [31:0] pc_out;
    logic        desvio_ex;
    logic [31:0] alvo_desvio;
    logic        stall_ext;
    logic        idex_le_mem;
    logic [4:0]  idex_rd;
    logic [31:0] saida_PC;
    logic [31:0] saida_MI;
    logic        saida_valido;
    logic        bolha_idex;
    logic [31:0] cont_stall;
    logic [31:0] cont_flush;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] LW = 32'h8C43_0000;

    if_id_fetch dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_mem    (instr_mem),
        .pc_out       (pc_out),
        .desvio_ex    (desvio_ex),
        .alvo_desvio  (alvo_desvio),
        .stall_ext    (stall_ext),
        .idex_le_mem  (idex_le_mem),
        .idex_rd      (idex_rd),
        .saida_PC     (saida_PC),
        .saida_MI     (saida_MI),
        .saida_valido (saida_valido),
        .bolha_idex   (bolha_idex),
        .cont_stall   (cont_stall),
        .cont_flush   (cont_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] id_pc,
                            input logic [31:0] id_mi, input logic vld);
        check({tag, ".pc_out"},       pc_out,       pc);
        check({tag, ".saida_PC"},     saida_PC,     id_pc);
        check({tag, ".saida_MI"},     saida_MI,     id_mi);
        check({tag, ".saida_valido"}, {31'd0, saida_valido}, {31'd0, vld});
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
`ifdef IF_ID_PERF_EN
        check({tag, ".cont_stall"}, cont_stall, st);
        check({tag, ".cont_flush"}, cont_flush, fl);
`else
        check({tag, ".cont_stall"}, cont_stall, 32'd0 & st);
        check({tag, ".cont_flush"}, cont_flush, 32'd0 & fl);
`endif
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_mem   = 32'h0;
        desvio_ex   = 1'b0;
        alvo_desvio = 32'h0;
        stall_ext   = 1'b0;
        idex_le_mem = 1'b0;
        idex_rd     = 5'd0;
        #2;
        step();
        step();
        check_id("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("reset", 32'd0, 32'd0);
        desvio_ex = 1'b1;
        settle();
        check("reset.bolha_blocked", {31'd0, bolha_idex}, 32'd0);
        desvio_ex = 1'b0;

        // Free-running sequence
        reset_n   = 1'b1;
        instr_mem = 32'h11;
        settle();
        check("seq.bolha", {31'd0, bolha_idex}, 32'd0);
        step();
        check_id("seq1", 32'd4, 32'd4, 32'h11, 1'b1);
        instr_mem = 32'h22;
        step();
        check_id("seq2", 32'd8, 32'd8, 32'h22, 1'b1);
        instr_mem = 32'h33;
        step();
        check_id("seq3", 32'd12, 32'd12, 32'h33, 1'b1);

        // Load-use on rt
        instr_mem = LW;
        step();
        check_id("lu_load", 32'd16, 32'd16, LW, 1'b1);
        idex_le_mem = 1'b1;
        idex_rd     = 5'd3;
        instr_mem   = 32'h44;
        settle();
        check("lu.bolha", {31'd0, bolha_idex}, 32'd1);
        step();
        check_id("lu_hold", 32'd16, 32'd16, LW, 1'b1);
        check_cnt("lu_hold", 32'd1, 32'd0);
        idex_le_mem = 1'b0;
        settle();
        check("lu.bubble_bolha", {31'd0, bolha_idex}, 32'd0);
        step();
        check_id("lu_adv", 32'd20, 32'd20, 32'h44, 1'b1);

        // rd=0 never stalls
        instr_mem = LW;
        step();
        idex_le_mem = 1'b1;
        idex_rd     = 5'd0;
        instr_mem   = 32'h55;
        settle();
        check("rd0.bolha", {31'd0, bolha_idex}, 32'd0);
        step();
        check_id("rd0_adv", 32'd28, 32'd28, 32'h55, 1'b1);

        // rs match and non-matching rd
        instr_mem = LW;
        idex_le_mem = 1'b0;
        step();
        idex_le_mem = 1'b1;
        idex_rd     = 5'd2;
        settle();
        check("rs.bolha", {31'd0, bolha_idex}, 32'd1);
        idex_rd = 5'd5;
        settle();
        check("nomatch.bolha", {31'd0, bolha_idex}, 32'd0);
        idex_le_mem = 1'b0;
        instr_mem   = 32'h66;
        step();
        check_id("rs_adv", 32'd36, 32'd36, 32'h66, 1'b1);

        // Redirect wins over freeze and hazard
        instr_mem = LW;
        step();
        idex_le_mem = 1'b1;
        idex_rd     = 5'd3;
        stall_ext   = 1'b1;
        desvio_ex   = 1'b1;
        alvo_desvio = 32'h100;
        settle();
        check("redir.bolha", {31'd0, bolha_idex}, 32'd1);
        step();
        check_id("redir", 32'h100, 32'h0, 32'h0, 1'b0);
        check_cnt("redir", 32'd1, 32'd1);
        desvio_ex   = 1'b0;
        stall_ext   = 1'b0;
        idex_le_mem = 1'b0;

        // Freeze
        instr_mem = 32'h77;
        step();
        check_id("pre_frz", 32'h104, 32'h104, 32'h77, 1'b1);
        stall_ext = 1'b1;
        instr_mem = 32'h88;
        settle();
        check("frz.bolha", {31'd0, bolha_idex}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_id("frz", 32'h104, 32'h104, 32'h77, 1'b1);
        check("frz.bolha_end", {31'd0, bolha_idex}, 32'd0);
        stall_ext = 1'b0;
        step();
        check_id("frz_rel", 32'h108, 32'h108, 32'h88, 1'b1);

        // Second stall, then reset while hazard is active
        instr_mem = LW;
        step();
        idex_le_mem = 1'b1;
        idex_rd     = 5'd3;
        step();
        check_id("lu2_hold", 32'h10C, 32'h10C, LW, 1'b1);
        check_cnt("lu2", 32'd2, 32'd1);
        reset_n = 1'b0;
        settle();
        check("rst_mid.bolha", {31'd0, bolha_idex}, 32'd0);
        step();
        check_id("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("rst_mid", 32'd0, 32'd0);
        reset_n     = 1'b1;
        idex_le_mem = 1'b0;

        // PC wrap
        desvio_ex   = 1'b1;
        alvo_desvio = 32'hFFFF_FFFC;
        step();
        check_id("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        desvio_ex = 1'b0;
        instr_mem = 32'h99;
        step();
        check_id("wrap", 32'h0, 32'h0, 32'h99, 1'b1);
        check_cnt("wrap", 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
